ahb_lite_master: RTL
====================

// Module: ahb_lite_master
// PURPOSE
//  AHB-Lite initiator: the manager-side counterpart to our AHB5 slave interface/VIP.
//  Turns simple word-burst commands (addr, dir, length) into pipelined AHB address/data
//  phases on Hclk. Honours Hready wait states, the two-cycle Hresp error and the 1KB
//  INCR boundary. Drives the bus that the slave clocking block samples.
// PARAMETERS
//  MAX_LEN   16       max beats per command (cmd_len range 1..MAX_LEN)
//  HPROT_VAL 4'b0011  constant Hprot (data, privileged)
// PORTS
//  Hclk        in   1   bus clock, all logic on posedge
//  HRESETn     in   1   async active-low reset
//  cmd_valid   in   1   command request
//  cmd_ready   out  1   high only in IDLE; command accepted on valid&&ready
//  cmd_addr    in   32  start byte addr; bits[1:0] ignored (forced 0)
//  cmd_write   in   1   1=write, 0=read
//  cmd_len     in   5   beats; 0 treated as 1, >MAX_LEN clamped
//  wdata_valid in   1   write data available
//  wdata       in   32  write data for current beat
//  wdata_ready out  1   pulses when a write beat's address phase completes (data taken)
//  rdata_valid out  1   one-cycle pulse per completed OKAY read beat
//  rdata       out  32  read data, valid with rdata_valid
//  done        out  1   one-cycle pulse when command ends (OKAY or ERROR)
//  err         out  1   qualifies done: 1 = command aborted by Hresp ERROR
//  Haddr       out  32  AHB address
//  Hwrite      out  1   AHB direction
//  Hsize       out  3   fixed 3'b010 (word)
//  Hburst      out  3   SINGLE(000) if len==1, else INCR(001)
//  Hprot       out  4   HPROT_VAL
//  Htrans      out  2   IDLE 00 / BUSY 01 / NONSEQ 10 / SEQ 11
//  Hmastlock   out  1   tied 0
//  Hwdata      out  32  write data, driven during data phase, held while Hready=0
//  Hready      in   1   bus ready (transfer completes when 1)
//  Hresp       in   1   0=OKAY 1=ERROR
//  Hrdata      in   32  read data
// BEHAVIOUR
//  Reset: Htrans=IDLE, Haddr/Hwdata/rdata=0, Hwrite=0, Hburst=0, cmd_ready=1,
//   all pulses 0, state IDLE. Reset mid-burst abandons command; no done.
//  States: IDLE -> BURST (accept cmd) -> DRAIN (last addr phase done, last data phase
//   pending) -> IDLE; any state with data phase -> ERR on Hresp=1&&Hready=0 -> IDLE.
//  Address outputs change only on posedge where Hready=1 (or no transfer pending).
//  Beat 1 NONSEQ; later beats SEQ, Haddr += 4. Write beat addr phase issued only if
//   wdata_valid; else drive BUSY (mid-burst) or IDLE (first beat), addr held.
//  Pipeline: data phase = cycle after addr phase accepted; rdata=Hrdata, rdata_valid
//   pulse on that data phase's Hready=1, Hresp=0. Hwdata from register loaded at
//   wdata_ready.
//  1KB rule: if next beat addr[9:0]==0, issue it NONSEQ (restarts INCR).
//  Error: cycle 1 (Hresp=1,Hready=0): next-cycle Htrans=IDLE, cancel remaining beats;
//   cycle 2 (Hresp=1,Hready=1): done=1, err=1. No rdata_valid for errored beat.
//  done pulses the cycle the final data phase completes; cmd_ready returns next cycle.
//  Min latency: cmd accept cycle N -> NONSEQ at N+1 -> single-beat done at N+2.
// TESTING
//  Read len=1 @0x100, Hready=1 -> NONSEQ/SINGLE @0x100, rdata_valid+done 2 cyc after accept.
//  Write len=4 @0x200, wdata 1..4 -> NONSEQ,SEQ,SEQ,SEQ @0x200..0x20C INCR, Hwdata 1..4.
//  Read len=4, slave Hready=0 for 2 cyc on beat 2 -> Haddr/Htrans held, 4 rdata_valid.
//  Write len=3, wdata_valid low 2 cyc after beat1 -> 2 BUSY cycles, then SEQ.
//  Read len=4 @0x3F8 -> beats 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ.
//  Hresp ERROR on beat 2 of len=4 -> IDLE next cycle, done=1 err=1, 1 rdata_valid only.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns word-burst commands (addr, dir, length) into
// pipelined AHB address/data phases, honouring wait states, the two-cycle
// ERROR response and the 1KB INCR boundary.
module ahb_lite_master #(
  parameter int         MAX_LEN   = 16,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        Hclk,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_len,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic [31:0] Haddr,
  output logic        Hwrite,
  output logic [2:0]  Hsize,
  output logic [2:0]  Hburst,
  output logic [3:0]  Hprot,
  output logic [1:0]  Htrans,
  output logic        Hmastlock,
  output logic [31:0] Hwdata,
  input  logic        Hready,
  input  logic        Hresp,
  input  logic [31:0] Hrdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;

  logic [1:0]  state;
  logic [4:0]  remaining;   // beats not yet placed on the bus as NONSEQ/SEQ
  logic [31:0] nextAddr;    // address of the next beat to issue
  logic        firstBeat;   // no beat of this command issued yet
  logic        dataPend;    // a real transfer is in its data phase this cycle
  logic        dataWrite;
  logic [31:0] wbuf;        // write data of the issued-but-unaccepted beat

  logic [4:0]  lenEff;
  logic        advance;
  logic        errStart;
  logic        curWrite;
  logic [31:0] curAddr;
  logic [4:0]  curLeft;
  logic        curFirst;
  logic        issueSlot;
  logic        issue;
  logic [1:0]  issueTrans;

  assign Hsize     = 3'b010;
  assign Hprot     = HPROT_VAL;
  assign Hmastlock = 1'b0;

  // The bus moves on when the pending data phase completes or none is pending;
  // the first ERROR cycle is the only case that overrides the address pipeline.
  assign advance  = Hready || !dataPend;
  assign errStart = dataPend && Hresp && !Hready;

  // Length 0 means one beat; anything above MAX_LEN is clamped.
  always_comb begin
    lenEff = cmd_len;
    if (cmd_len == 5'd0)
      lenEff = 5'd1;
    else if (cmd_len > 5'(MAX_LEN))
      lenEff = 5'(MAX_LEN);
  end

  // Decide whether this edge launches a beat; in IDLE the candidate beat comes
  // straight from the command, in BURST from the saved burst progress.
  always_comb begin
    curWrite  = Hwrite;
    curAddr   = nextAddr;
    curLeft   = remaining;
    curFirst  = firstBeat;
    issueSlot = (state == ST_BURST) && advance && !errStart;
    if (state == ST_IDLE) begin
      curWrite  = cmd_write;
      curAddr   = cmd_addr & 32'hFFFF_FFFC;
      curLeft   = lenEff;
      curFirst  = 1'b1;
      issueSlot = cmd_valid;
    end
    issue      = issueSlot && (curLeft != 5'd0) && (!curWrite || wdata_valid);
    issueTrans = (curFirst || (curAddr[9:0] == 10'd0)) ? TR_NONSEQ : TR_SEQ;
  end

  assign cmd_ready   = (state == ST_IDLE);
  assign wdata_ready = issue && curWrite;
  assign rdata_valid = dataPend && !dataWrite && Hready && !Hresp;
  assign rdata       = rdata_valid ? Hrdata : 32'd0;
  assign done        = ((state == ST_DRAIN) || (state == ST_ERR)) && Hready;
  assign err         = (state == ST_ERR) && Hready;

  // Command sequencing, address-phase issue and data-phase tracking.
  always_ff @(posedge Hclk or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      Haddr     <= 32'd0;
      Htrans    <= TR_IDLE;
      Hwrite    <= 1'b0;
      Hburst    <= HB_SINGLE;
      Hwdata    <= 32'd0;
      wbuf      <= 32'd0;
      nextAddr  <= 32'd0;
      remaining <= 5'd0;
      firstBeat <= 1'b0;
      dataPend  <= 1'b0;
      dataWrite <= 1'b0;
    end else if (state == ST_ERR) begin
      if (Hready) begin
        dataPend <= 1'b0;
        state    <= ST_IDLE;
      end
    end else if (errStart) begin
      Htrans    <= TR_IDLE;
      remaining <= 5'd0;
      state     <= ST_ERR;
    end else begin
      if (advance) begin
        dataPend  <= Htrans[1];
        dataWrite <= Hwrite;
        if (Htrans[1] && Hwrite)
          Hwdata <= wbuf;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            Hwrite <= cmd_write;
            Hburst <= (lenEff == 5'd1) ? HB_SINGLE : HB_INCR;
            state  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (advance && Htrans[1] && (remaining == 5'd0)) begin
            Htrans <= TR_IDLE;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (Hready)
            state <= ST_IDLE;
        end
        default: begin
        end
      endcase
      if (issue) begin
        Htrans    <= issueTrans;
        Haddr     <= curAddr;
        nextAddr  <= curAddr + 32'd4;
        remaining <= curLeft - 5'd1;
        firstBeat <= 1'b0;
        if (curWrite)
          wbuf <= wdata;
      end else if (issueSlot && (curLeft != 5'd0)) begin
        Htrans    <= curFirst ? TR_IDLE : TR_BUSY;
        nextAddr  <= curAddr;
        remaining <= curLeft;
        firstBeat <= curFirst;
      end
    end
  end

endmodule
